// File: rtl/fetch_stage.sv
// fetch_stage
//  Instruction fetch stage. Owns the PC and issues in-order word fetches on an
//  SRAM-like bus. Returned words are buffered together with the PC they were
//  fetched from, and the buffer head is presented to decode as
//  IF_ID_BUS = {ins[31:0], pc[31:2]}.
//  A redirect from a later stage flushes the buffer. Responses that are still
//  in flight are counted and then discarded when they return.
//  A misaligned redirect target produces a single address-error entry. Fetch
//  then halts until the next redirect.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [61:0] IF_ID_BUS,
   output logic        if_adel
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
   localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

   // fetch_st encodings
   localparam logic [1:0] ST_RUN       = 2'd0;
   localparam logic [1:0] ST_DRAIN     = 2'd1;
   localparam logic [1:0] ST_HALT_ADEL = 2'd2;

   // control state
   logic [31:0]   pc_r;
   logic [1:0]    fetch_st_r;
   logic [1:0]    fetch_st_nx_s;
   logic [CW-1:0] outstanding_r;
   logic [CW-1:0] drop_cnt_r;
   logic [CW-1:0] out_nx_s;
   logic [CW-1:0] drop_nx_s;

   // PC tags of accepted requests, consumed in order by responses
   logic [29:0]   tag_mem_r [DEPTH];
   logic [PW-1:0] tag_wp_r;
   logic [PW-1:0] tag_rp_r;

   // instruction buffer presented to decode
   logic [31:0]   fifo_ins_r  [DEPTH];
   logic [29:0]   fifo_pc_r   [DEPTH];
   logic          fifo_adel_r [DEPTH];
   logic [PW-1:0] fifo_wp_r;
   logic [PW-1:0] fifo_rp_r;
   logic [CW-1:0] fifo_cnt_r;

   // per-cycle qualifiers
   logic [CW:0]   credit_s;
   logic          pc_aligned_s;
   logic          can_fetch_s;
   logic          issue_s;
   logic          accept_s;
   logic          resp_s;
   logic          resp_keep_s;
   logic          adel_push_s;
   logic          push_s;
   logic          pop_s;
   logic [31:0]   wr_ins_s;
   logic [29:0]   wr_pc_s;
   logic          wr_adel_s;

   // Decode this cycle's issue, accept, response and buffer events.
   // The request depends only on registered state, redirect_valid and reset,
   // so there is no combinational path from inst_addr_ok to inst_req.
   always_comb begin
      credit_s     = {1'b0, outstanding_r} + {1'b0, fifo_cnt_r};
      pc_aligned_s = (pc_r[1:0] == 2'b00);
      can_fetch_s  = (fetch_st_r == ST_RUN) && (drop_cnt_r == CNT_ZERO) && !redirect_valid;
      issue_s      = resetn && can_fetch_s && pc_aligned_s && (credit_s < {1'b0, DEPTH_C});
      accept_s     = issue_s && inst_addr_ok;
      resp_s       = inst_data_ok && (outstanding_r != CNT_ZERO);
      resp_keep_s  = resp_s && !redirect_valid && (drop_cnt_r == CNT_ZERO);
      adel_push_s  = can_fetch_s && !pc_aligned_s && (outstanding_r == CNT_ZERO) &&
                     (fifo_cnt_r < DEPTH_C);
      push_s       = resp_keep_s || adel_push_s;
      pop_s        = (fifo_cnt_r != CNT_ZERO) && id_ready && !redirect_valid;
   end

   // Next values of the outstanding and drop counters.
   // A redirect turns every request still in flight into one that must be dropped.
   always_comb begin
      out_nx_s  = outstanding_r;
      drop_nx_s = drop_cnt_r;
      if (accept_s && !resp_s) begin
         out_nx_s = outstanding_r + CNT_ONE;
      end else if (!accept_s && resp_s) begin
         out_nx_s = outstanding_r - CNT_ONE;
      end else begin
         out_nx_s = outstanding_r;
      end
      if (redirect_valid) begin
         drop_nx_s = out_nx_s;
      end else if (resp_s && (drop_cnt_r != CNT_ZERO)) begin
         drop_nx_s = drop_cnt_r - CNT_ONE;
      end else begin
         drop_nx_s = drop_cnt_r;
      end
   end

   // Fetch state machine. A redirect overrides every state.
   always_comb begin
      fetch_st_nx_s = fetch_st_r;
      if (redirect_valid) begin
         if (drop_nx_s != CNT_ZERO) begin
            fetch_st_nx_s = ST_DRAIN;
         end else begin
            fetch_st_nx_s = ST_RUN;
         end
      end else begin
         case (fetch_st_r)
            ST_RUN: begin
               if (adel_push_s) begin
                  fetch_st_nx_s = ST_HALT_ADEL;
               end else begin
                  fetch_st_nx_s = ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (drop_nx_s == CNT_ZERO) begin
                  fetch_st_nx_s = ST_RUN;
               end else begin
                  fetch_st_nx_s = ST_DRAIN;
               end
            end
            ST_HALT_ADEL: fetch_st_nx_s = ST_HALT_ADEL;
            default:      fetch_st_nx_s = ST_RUN;
         endcase
      end
   end

   // Select the buffer write data: either an address-error entry or a fetched word.
   always_comb begin
      if (adel_push_s) begin
         wr_ins_s  = 32'h0000_0000;
         wr_pc_s   = pc_r[31:2];
         wr_adel_s = 1'b1;
      end else begin
         wr_ins_s  = inst_rdata;
         wr_pc_s   = tag_mem_r[tag_rp_r];
         wr_adel_s = 1'b0;
      end
   end

   // Update the PC, the fetch state and the in-flight counters.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_r          <= RESET_PC;
         fetch_st_r    <= ST_RUN;
         outstanding_r <= CNT_ZERO;
         drop_cnt_r    <= CNT_ZERO;
      end else begin
         fetch_st_r    <= fetch_st_nx_s;
         outstanding_r <= out_nx_s;
         drop_cnt_r    <= drop_nx_s;
         if (redirect_valid) begin
            pc_r <= redirect_pc;
         end else if (accept_s) begin
            pc_r <= pc_r + 32'd4;
         end else begin
            pc_r <= pc_r;
         end
      end
   end

   // PC tag queue. Dropped responses still consume their tag, so the queue
   // stays aligned with the bus.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tag_wp_r <= PTR_ZERO;
         tag_rp_r <= PTR_ZERO;
         for (int i = 0; i < int'(DEPTH); i++) begin
            tag_mem_r[i] <= 30'h0000_0000;
         end
      end else begin
         if (accept_s) begin
            tag_mem_r[tag_wp_r] <= pc_r[31:2];
            tag_wp_r            <= tag_wp_r + PTR_ONE;
         end
         if (resp_s) begin
            tag_rp_r <= tag_rp_r + PTR_ONE;
         end
      end
   end

   // Instruction buffer. A redirect empties it; otherwise a push and a pop in
   // the same cycle are both performed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fifo_wp_r  <= PTR_ZERO;
         fifo_rp_r  <= PTR_ZERO;
         fifo_cnt_r <= CNT_ZERO;
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_ins_r[i]  <= 32'h0000_0000;
            fifo_pc_r[i]   <= 30'h0000_0000;
            fifo_adel_r[i] <= 1'b0;
         end
      end else if (redirect_valid) begin
         fifo_wp_r  <= PTR_ZERO;
         fifo_rp_r  <= PTR_ZERO;
         fifo_cnt_r <= CNT_ZERO;
      end else begin
         if (push_s) begin
            fifo_ins_r[fifo_wp_r]  <= wr_ins_s;
            fifo_pc_r[fifo_wp_r]   <= wr_pc_s;
            fifo_adel_r[fifo_wp_r] <= wr_adel_s;
            fifo_wp_r              <= fifo_wp_r + PTR_ONE;
         end
         if (pop_s) begin
            fifo_rp_r <= fifo_rp_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_ONE;
            2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_ONE;
            default: fifo_cnt_r <= fifo_cnt_r;
         endcase
      end
   end

   // Present the buffer head to decode. The bus reads as zero when the buffer is empty.
   always_comb begin
      if_valid = (fifo_cnt_r != CNT_ZERO);
      if (fifo_cnt_r != CNT_ZERO) begin
         IF_ID_BUS = {fifo_ins_r[fifo_rp_r], fifo_pc_r[fifo_rp_r]};
         if_adel   = fifo_adel_r[fifo_rp_r];
      end else begin
         IF_ID_BUS = 62'h0;
         if_adel   = 1'b0;
      end
   end

   assign inst_req  = issue_s;
   assign inst_addr = pc_r;

endmodule
